frame_color_analyzer: RTL and testbench

Parametrised successor to the single-shot colour analyser in the camera test SoC. After a frame has been captured into the dual-port frame buffer, it scans a programmable region of interest (ROI) through the buffer's read port. It classifies each RGB332 pixel as red, green, blue or none, and accumulates per-colour counts. It then reports either the single dominant colour or a colour-presence bitmap to the LM32 peripheral, with a one-cycle done pulse.

---
 rtl/frame_color_analyzer.sv | 216 +++++++++++++++++++++
 tb/tb_frame_color_analyzer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_color_analyzer.sv
// frame_color_analyzer: scans a region of interest of a captured RGB332 frame
// through the frame-buffer read port and classifies each pixel as red, green,
// blue or none. It reports either the dominant colour or a presence bitmap,
// then pulses done for one cycle.
module frame_color_analyzer #(
   parameter int SCREEN_X  = 160,
   parameter int SCREEN_Y  = 120,
   parameter int AW        = 15,
   parameter int XW        = 8,
   parameter int YW        = 7,
   parameter int CW        = 16,
   parameter int RD_LAT    = 1,
   parameter int CH_MIN    = 3,
   parameter int MIN_COUNT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic          mode,
   input  logic [XW-1:0] roi_x0,
   input  logic [YW-1:0] roi_y0,
   input  logic [XW-1:0] roi_x1,
   input  logic [YW-1:0] roi_y1,
   output logic [AW-1:0] addr,
   input  logic [7:0]    data,
   output logic          busy,
   output logic          done,
   output logic [2:0]    result,
   output logic [CW-1:0] red_count,
   output logic [CW-1:0] green_count,
   output logic [CW-1:0] blue_count
);

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_DECIDE, S_DONE} state_t;

   localparam logic [XW-1:0] X_MAX      = XW'(SCREEN_X - 1);
   localparam logic [YW-1:0] Y_MAX      = YW'(SCREEN_Y - 1);
   localparam logic [AW-1:0] ROW_STEP   = AW'(SCREEN_X);
   localparam logic [2:0]    CH_MIN_L   = 3'(CH_MIN);
   localparam logic [CW-1:0] MIN_CNT_L  = CW'(MIN_COUNT);
   localparam logic [1:0]    DRAIN_LAST = 2'(RD_LAT - 1);

   state_t          state_q, state_d;
   logic            mode_q;
   logic [XW-1:0]   x_q, x0_q, x1_q;
   logic [YW-1:0]   y_q, y1_q;
   logic [AW-1:0]   row_q;
   logic [1:0]      drain_q;
   logic [RD_LAT-1:0] vld;

   logic            roi_bad;
   logic [XW-1:0]   vx0, vx1;
   logic [YW-1:0]   vy0, vy1;
   logic            last_pix;
   logic [2:0]      r, g, b3;
   logic            is_red, is_green, is_blue;
   logic [2:0]      next_result;

   // ROI validation: any malformed or out-of-frame window falls back to the full frame.
   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      roi_bad = (roi_x0 > roi_x1) || (roi_y0 > roi_y1) ||
                (roi_x1 > X_MAX)  || (roi_y1 > Y_MAX);
      vx0 = roi_x0;
      vy0 = roi_y0;
      vx1 = roi_x1;
      vy1 = roi_y1;
      if (roi_bad) begin
         vx0 = '0;
         vy0 = '0;
         vx1 = X_MAX;
         vy1 = Y_MAX;
      end
   end

   assign last_pix = (x_q == x1_q) && (y_q == y1_q);

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and status outputs decoded from the state.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE:   if (init) state_d = S_SCAN;
         S_SCAN:   begin
                      busy = 1'b1;
                      if (last_pix) state_d = S_DRAIN;
                   end
         S_DRAIN:  begin
                      busy = 1'b1;
                      if (drain_q == DRAIN_LAST) state_d = S_DECIDE;
                   end
         S_DECIDE: begin
                      busy    = 1'b1;
                      state_d = S_DONE;
                   end
         S_DONE:   begin
                      done    = 1'b1;
                      state_d = S_IDLE;
                   end
         default:  state_d = S_IDLE;
      endcase
   end

   // ROI latch, raster walk with a row-base accumulator, drain timer and result register.
   // The only product is the start row times a constant width, taken once at init.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         x0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         row_q   <= '0;
         addr    <= '0;
         drain_q <= '0;
         result  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (init) begin
               mode_q <= mode;
               x0_q   <= vx0;
               x1_q   <= vx1;
               y1_q   <= vy1;
               x_q    <= vx0;
               y_q    <= vy0;
               row_q  <= AW'(vy0) * ROW_STEP;
               addr   <= AW'(vy0) * ROW_STEP + AW'(vx0);
               result <= '0;
            end
            S_SCAN: begin
               drain_q <= '0;
               if (!last_pix) begin
                  if (x_q == x1_q) begin
                     x_q   <= x0_q;
                     y_q   <= y_q + 1'b1;
                     row_q <= row_q + ROW_STEP;
                     addr  <= row_q + ROW_STEP + AW'(x0_q);
                  end else begin
                     x_q  <= x_q + 1'b1;
                     addr <= addr + 1'b1;
                  end
               end
            end
            S_DRAIN:  drain_q <= drain_q + 1'b1;
            S_DECIDE: result  <= next_result;
            default: ;
         endcase
      end
   end

   // Valid bit travels alongside each issued address for the read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
      end else begin
         vld[0] <= (state_q == S_SCAN);
         for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
      end
   end

   // Pixel classification: a channel wins only if it clears the floor and strictly beats both others.
   always_comb begin
      r        = data[7:5];
      g        = data[4:2];
      b3       = {data[1:0], data[1]};
      is_red   = (r  >= CH_MIN_L) && (r  > g) && (r  > b3);
      is_green = (g  >= CH_MIN_L) && (g  > r) && (g  > b3);
      is_blue  = (b3 >= CH_MIN_L) && (b3 > r) && (b3 > g);
   end

   // Per-colour saturating counters, cleared when a new scan is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         red_count   <= '0;
         green_count <= '0;
         blue_count  <= '0;
      end else if (state_q == S_IDLE && init) begin
         red_count   <= '0;
         green_count <= '0;
         blue_count  <= '0;
      end else if (vld[RD_LAT-1]) begin
         if (is_red   && !(&red_count))   red_count   <= red_count   + 1'b1;
         if (is_green && !(&green_count)) green_count <= green_count + 1'b1;
         if (is_blue  && !(&blue_count))  blue_count  <= blue_count  + 1'b1;
      end
   end

   // Result decision: dominant one-hot (strict maximum above threshold) or presence bitmap.
   always_comb begin
      next_result = 3'b000;
      if (mode_q) begin
         next_result = {red_count   >= MIN_CNT_L,
                        green_count >= MIN_CNT_L,
                        blue_count  >= MIN_CNT_L};
      end else if (red_count > green_count && red_count > blue_count &&
                   red_count >= MIN_CNT_L) begin
         next_result = 3'b100;
      end else if (green_count > red_count && green_count > blue_count &&
                   green_count >= MIN_CNT_L) begin
         next_result = 3'b010;
      end else if (blue_count > red_count && blue_count > green_count &&
                   blue_count >= MIN_CNT_L) begin
         next_result = 3'b001;
      end
   end

endmodule

// File: tb/tb_frame_color_analyzer.sv
// Bench for frame_color_analyzer on an 8x4 frame, two instances with read
// latencies 1 and 3 fed from one frame-buffer model.
module tb_frame_color_analyzer;

   localparam int SX = 8;
   localparam int SY = 4;
   localparam int AW = 5;
   localparam int XW = 4;
   localparam int YW = 3;
   localparam int CW = 16;
   localparam int MINC = 4;

   typedef struct {
      logic          mode;
      logic [XW-1:0] x0;
      logic [YW-1:0] y0;
      logic [XW-1:0] x1;
      logic [YW-1:0] y1;
      int            pat;
      int            n;
      logic [2:0]    res;
      int            rc;
      int            gc;
      int            bc;
   } vec_t;

   typedef struct {
      logic [2:0]    res;
      logic [CW-1:0] rc;
      logic [CW-1:0] gc;
      logic [CW-1:0] bc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst, init, mode;
   logic [XW-1:0] roi_x0, roi_x1;
   logic [YW-1:0] roi_y0, roi_y1;
   logic [AW-1:0] addr_o [2];
   logic [7:0]    data_i [2];
   logic          busy_o [2];
   logic          done_o [2];
   logic [2:0]    result_o [2];
   logic [CW-1:0] rc_o [2];
   logic [CW-1:0] gc_o [2];
   logic [CW-1:0] bc_o [2];

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]    fb [0:SX*SY-1];
   logic [7:0]    p1;
   logic [7:0]    p3 [0:2];

   logic [AW-1:0] aq0 [$];
   logic [AW-1:0] aq1 [$];
   exp_t          rq0 [$];
   exp_t          rq1 [$];

   always #5 clk = ~clk;

   // Frame-buffer read ports: latency 1 and latency 3.
   always @(posedge clk) begin
      p1    <= fb[addr_o[0]];
      p3[0] <= fb[addr_o[1]];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign data_i[0] = p1;
   assign data_i[1] = p3[2];

   frame_color_analyzer #(
      .SCREEN_X(SX), .SCREEN_Y(SY), .AW(AW), .XW(XW), .YW(YW), .CW(CW),
      .RD_LAT(1), .CH_MIN(3), .MIN_COUNT(MINC)
   ) dut_l1 (
      .clk(clk), .rst(rst), .init(init), .mode(mode),
      .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_x1(roi_x1), .roi_y1(roi_y1),
      .addr(addr_o[0]), .data(data_i[0]), .busy(busy_o[0]), .done(done_o[0]),
      .result(result_o[0]), .red_count(rc_o[0]), .green_count(gc_o[0]),
      .blue_count(bc_o[0])
   );

   frame_color_analyzer #(
      .SCREEN_X(SX), .SCREEN_Y(SY), .AW(AW), .XW(XW), .YW(YW), .CW(CW),
      .RD_LAT(3), .CH_MIN(3), .MIN_COUNT(MINC)
   ) dut_l3 (
      .clk(clk), .rst(rst), .init(init), .mode(mode),
      .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_x1(roi_x1), .roi_y1(roi_y1),
      .addr(addr_o[1]), .data(data_i[1]), .busy(busy_o[1]), .done(done_o[1]),
      .result(result_o[1]), .red_count(rc_o[1]), .green_count(gc_o[1]),
      .blue_count(bc_o[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Frame patterns: counts listed are for the whole 32-pixel frame.
   //  0: all E0 (red 32)
   //  1: 0..9 E0, 10..14 1C, rest 00 (red 10, green 5)
   //  2: 0..5 E0, 6..11 03, rest 00 (red 6, blue 6)
   //  3: all 90 (r=g=4 tie, none)
   //  4: 0..4 03, 5..8 1C, 9..10 E0 (blue 5, green 4, red 2)
   //  5: 0..4 60 (r=3), 5..9 40 (r=2 below floor), 10..13 0C (g=3), 14..18 03, 19..23 01 (b3=2)
   function automatic logic [7:0] pix(input int p, input int i);
      case (p)
         0: return 8'hE0;
         1: return (i < 10) ? 8'hE0 : (i < 15) ? 8'h1C : 8'h00;
         2: return (i < 6) ? 8'hE0 : (i < 12) ? 8'h03 : 8'h00;
         3: return 8'h90;
         4: return (i < 5) ? 8'h03 : (i < 9) ? 8'h1C : (i < 11) ? 8'hE0 : 8'h00;
         5: return (i < 5) ? 8'h60 : (i < 10) ? 8'h40 : (i < 14) ? 8'h0C :
                   (i < 19) ? 8'h03 : (i < 24) ? 8'h01 : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic load_pattern(input int p);
      for (int i = 0; i < SX*SY; i++) fb[i] = pix(p, i);
   endtask

   task automatic check_zero(input string name, input int k);
      check($sformatf("%s dut%0d busy", name, k), busy_o[k], 0);
      check($sformatf("%s dut%0d done", name, k), done_o[k], 0);
      check($sformatf("%s dut%0d addr", name, k), addr_o[k], 0);
      check($sformatf("%s dut%0d result", name, k), result_o[k], 0);
      check($sformatf("%s dut%0d red", name, k), rc_o[k], 0);
      check($sformatf("%s dut%0d green", name, k), gc_o[k], 0);
      check($sformatf("%s dut%0d blue", name, k), bc_o[k], 0);
   endtask

   task automatic run_scan(input vec_t v, input bit extra, input string name);
      int            ex0, ey0, ex1, ey1;
      int            dcyc [2];
      int            npulse [2];
      exp_t          e, got;
      logic [AW-1:0] a;
      int            lat [2];
      lat[0] = 1;
      lat[1] = 3;
      load_pattern(v.pat);
      ex0 = v.x0; ey0 = v.y0; ex1 = v.x1; ey1 = v.y1;
      if (ex0 > ex1 || ey0 > ey1 || ex1 > SX-1 || ey1 > SY-1) begin
         ex0 = 0; ey0 = 0; ex1 = SX-1; ey1 = SY-1;
      end
      for (int y = ey0; y <= ey1; y++)
         for (int x = ex0; x <= ex1; x++) begin
            aq0.push_back(AW'(y*SX + x));
            aq1.push_back(AW'(y*SX + x));
         end
      e.res = v.res;
      e.rc  = CW'(v.rc);
      e.gc  = CW'(v.gc);
      e.bc  = CW'(v.bc);
      rq0.push_back(e);
      rq1.push_back(e);

      @(negedge clk);
      mode = v.mode; roi_x0 = v.x0; roi_y0 = v.y0; roi_x1 = v.x1; roi_y1 = v.y1;
      init = 1'b1;
      dcyc[0] = -1; dcyc[1] = -1;
      npulse[0] = 0; npulse[1] = 0;
      for (int c = 1; c <= v.n + 8; c++) begin
         @(negedge clk);
         init = extra && (c == 3 || c == v.n - 1 || c == v.n + 2);
         if (extra && c == 2) begin
            mode = ~v.mode; roi_x0 = '0; roi_y0 = '0; roi_x1 = '0; roi_y1 = '0;
         end
         for (int k = 0; k < 2; k++) begin
            if (c == 1) check($sformatf("%s dut%0d busy c1", name, k), busy_o[k], 1);
            if (c <= v.n) begin
               a = 'x;
               if (k == 0 && aq0.size() > 0) a = aq0.pop_front();
               if (k == 1 && aq1.size() > 0) a = aq1.pop_front();
               check($sformatf("%s dut%0d addr c%0d", name, k, c), addr_o[k], a);
            end
            if (done_o[k]) begin
               npulse[k]++;
               if (dcyc[k] < 0) begin
                  dcyc[k] = c;
                  got.res = 'x; got.rc = 'x; got.gc = 'x; got.bc = 'x;
                  if (k == 0 && rq0.size() > 0) got = rq0.pop_front();
                  if (k == 1 && rq1.size() > 0) got = rq1.pop_front();
                  check($sformatf("%s dut%0d result", name, k), result_o[k], got.res);
                  check($sformatf("%s dut%0d red", name, k), rc_o[k], got.rc);
                  check($sformatf("%s dut%0d green", name, k), gc_o[k], got.gc);
                  check($sformatf("%s dut%0d blue", name, k), bc_o[k], got.bc);
               end
            end
         end
      end
      init = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s dut%0d done cycle", name, k), dcyc[k], v.n + lat[k] + 2);
         check($sformatf("%s dut%0d done pulses", name, k), npulse[k], 1);
         check($sformatf("%s dut%0d busy after", name, k), busy_o[k], 0);
         check($sformatf("%s dut%0d result held", name, k), result_o[k], e.res);
         check($sformatf("%s dut%0d red held", name, k), rc_o[k], e.rc);
      end
      check($sformatf("%s addr left dut0", name), aq0.size(), 0);
      check($sformatf("%s addr left dut1", name), aq1.size(), 0);
      check($sformatf("%s result left dut0", name), rq0.size(), 0);
      check($sformatf("%s result left dut1", name), rq1.size(), 0);
      aq0.delete(); aq1.delete(); rq0.delete(); rq1.delete();
   endtask

   task automatic reset_mid_scan();
      int np;
      load_pattern(0);
      @(negedge clk);
      mode = 1'b0; roi_x0 = 0; roi_y0 = 0; roi_x1 = 7; roi_y1 = 3;
      init = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         init = 1'b0;
         if (c == 10) rst = 1'b1;
      end
      @(negedge clk);
      check_zero("mid-scan rst", 0);
      check_zero("mid-scan rst", 1);
      rst = 1'b0;
      np = 0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (done_o[0]) np++;
         if (done_o[1]) np++;
      end
      check("no done after rst", np, 0);
   endtask

   initial begin
      vec_t tbl [14];
      tbl[0]  = '{1'b0, 4'd0, 3'd0, 4'd7, 3'd3, 0, 32, 3'b100, 32, 0, 0};
      tbl[1]  = '{1'b0, 4'd0, 3'd0, 4'd7, 3'd3, 1, 32, 3'b100, 10, 5, 0};
      tbl[2]  = '{1'b1, 4'd0, 3'd0, 4'd7, 3'd3, 1, 32, 3'b110, 10, 5, 0};
      tbl[3]  = '{1'b0, 4'd0, 3'd0, 4'd7, 3'd3, 2, 32, 3'b000, 6, 0, 6};
      tbl[4]  = '{1'b1, 4'd0, 3'd0, 4'd7, 3'd3, 2, 32, 3'b101, 6, 0, 6};
      tbl[5]  = '{1'b0, 4'd2, 3'd1, 4'd3, 3'd2, 1, 4,  3'b000, 0, 2, 0};
      tbl[6]  = '{1'b0, 4'd5, 3'd0, 4'd2, 3'd3, 0, 32, 3'b100, 32, 0, 0};
      tbl[7]  = '{1'b1, 4'd0, 3'd0, 4'd8, 3'd3, 5, 32, 3'b111, 5, 4, 5};
      tbl[8]  = '{1'b0, 4'd0, 3'd0, 4'd7, 3'd3, 5, 32, 3'b000, 5, 4, 5};
      tbl[9]  = '{1'b1, 4'd7, 3'd3, 4'd7, 3'd3, 0, 1,  3'b000, 1, 0, 0};
      tbl[10] = '{1'b1, 4'd0, 3'd0, 4'd7, 3'd0, 1, 8,  3'b100, 8, 0, 0};
      tbl[11] = '{1'b0, 4'd0, 3'd0, 4'd7, 3'd4, 4, 32, 3'b001, 2, 4, 5};
      tbl[12] = '{1'b0, 4'd0, 3'd1, 4'd7, 3'd3, 1, 24, 3'b010, 2, 5, 0};
      tbl[13] = '{1'b0, 4'd0, 3'd0, 4'd7, 3'd3, 3, 32, 3'b000, 0, 0, 0};

      rst = 1'b1; init = 1'b0; mode = 1'b0;
      roi_x0 = '0; roi_y0 = '0; roi_x1 = '0; roi_y1 = '0;
      load_pattern(0);
      repeat (3) @(negedge clk);
      check_zero("reset", 0);
      check_zero("reset", 1);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) run_scan(tbl[i], 1'b0, $sformatf("vec%0d", i));

      run_scan(tbl[13], 1'b1, "init while busy");
      reset_mid_scan();
      run_scan(tbl[0], 1'b0, "after rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
